// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: LSL/LSR/ASR/ROR/ROL, one binary-weighted shift stage per register.
// Optional zero/carry flags are built when SHIFTER_FLAGS_EN is defined.
module pipelined_barrel_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [7:0]       in_offset,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef SHIFTER_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_carry
`endif
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [7:0] W_OFF = 8'(WIDTH);

    localparam logic [2:0] MODE_LSL = 3'b000;
    localparam logic [2:0] MODE_LSR = 3'b001;
    localparam logic [2:0] MODE_ASR = 3'b010;
    localparam logic [2:0] MODE_ROR = 3'b011;
    localparam logic [2:0] MODE_ROL = 3'b100;

    // One conditional shift step; ASR refills from the current MSB, which always
    // equals the original sign bit because every earlier step preserved it.
    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                    input logic [2:0] mode,
                                                    input int sh);
        logic [2*WIDTH-1:0] dd;
        logic [2*WIDTH-1:0] wrapped;
        logic [WIDTH-1:0]   res;
        dd      = {d, d};
        wrapped = '0;
        res     = d;
        case (mode)
            MODE_LSL: res = d << sh;
            MODE_LSR: res = d >> sh;
            MODE_ASR: res = $signed(d) >>> sh;
            MODE_ROR: begin
                wrapped = dd >> sh;
                res     = wrapped[WIDTH-1:0];
            end
            MODE_ROL: begin
                wrapped = dd << sh;
                res     = wrapped[2*WIDTH-1:WIDTH];
            end
            default:  res = d;
        endcase
        return res;
    endfunction

    logic             en;
    logic             valid_reg [0:SHW];
    logic [WIDTH-1:0] data_reg  [0:SHW];
    logic [2:0]       mode_reg  [0:SHW-1];
    logic [SHW-1:0]   amt_reg   [0:SHW-1];
    logic [WIDTH-1:0] step_data [1:SHW];

    logic             is_rot;
    logic             is_pass;
    logic             ovf;
    logic [SHW-1:0]   amt_next;
    logic [WIDTH-1:0] data_next;

    assign en        = !valid_reg[SHW] || out_ready;
    assign in_ready  = en;
    assign out_valid = valid_reg[SHW];
    assign out_data  = data_reg[SHW];

    // Overflowing shifts are resolved up front, so later stages only ever see
    // an in-range amount (zero for overflow and pass-through).
    always_comb begin
        is_rot    = (in_mode == MODE_ROR) || (in_mode == MODE_ROL);
        is_pass   = (in_mode > MODE_ROL);
        ovf       = !is_rot && !is_pass && (in_offset >= W_OFF);
        amt_next  = (is_pass || ovf) ? '0 : in_offset[SHW-1:0];
        data_next = in_data;
        if (ovf) begin
            data_next = (in_mode == MODE_ASR) ? {WIDTH{in_data[WIDTH-1]}} : '0;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi <= SHW; gi++) begin : g_stage
            assign step_data[gi] = amt_reg[gi-1][gi-1]
                                 ? shift_step(data_reg[gi-1], mode_reg[gi-1], 1 << (gi - 1))
                                 : data_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= SHW; i++) begin
                valid_reg[i] <= 1'b0;
                data_reg[i]  <= '0;
            end
            for (int i = 0; i < SHW; i++) begin
                mode_reg[i] <= '0;
                amt_reg[i]  <= '0;
            end
        end else if (en) begin
            valid_reg[0] <= in_valid;
            data_reg[0]  <= data_next;
            mode_reg[0]  <= in_mode;
            amt_reg[0]   <= amt_next;
            for (int i = 1; i <= SHW; i++) begin
                valid_reg[i] <= valid_reg[i-1];
                data_reg[i]  <= step_data[i];
            end
            for (int i = 1; i < SHW; i++) begin
                mode_reg[i] <= mode_reg[i-1];
                amt_reg[i]  <= amt_reg[i-1];
            end
        end
    end

`ifdef SHIFTER_FLAGS_EN
    // Shift carries depend only on the input and are tapped at entry; rotate
    // carries come from the finished result, so only a "rotated at all" bit travels.
    logic             carry_reg [0:SHW-1];
    logic             rnz_reg   [0:SHW-1];
    logic             zero_out_reg;
    logic             carry_out_reg;
    logic             carry_next;
    logic             rnz_next;
    logic [WIDTH-1:0] tap_mask;
    logic             carry_last;

    always_comb begin
        carry_next = 1'b0;
        tap_mask   = '0;
        rnz_next   = is_rot && (amt_next != '0);
        if (in_offset != 8'd0 && in_offset <= W_OFF) begin
            case (in_mode)
                MODE_LSL: tap_mask = WIDTH'(1) << (W_OFF - in_offset);
                MODE_LSR,
                MODE_ASR: tap_mask = WIDTH'(1) << (in_offset - 8'd1);
                default:  tap_mask = '0;
            endcase
            carry_next = |(in_data & tap_mask);
        end else if (in_offset > W_OFF && in_mode == MODE_ASR) begin
            carry_next = in_data[WIDTH-1];
        end
    end

    always_comb begin
        carry_last = carry_reg[SHW-1];
        if (rnz_reg[SHW-1]) begin
            carry_last = (mode_reg[SHW-1] == MODE_ROR) ? step_data[SHW][WIDTH-1]
                                                       : step_data[SHW][0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SHW; i++) begin
                carry_reg[i] <= 1'b0;
                rnz_reg[i]   <= 1'b0;
            end
            zero_out_reg  <= 1'b0;
            carry_out_reg <= 1'b0;
        end else if (en) begin
            carry_reg[0] <= carry_next;
            rnz_reg[0]   <= rnz_next;
            for (int i = 1; i < SHW; i++) begin
                carry_reg[i] <= carry_reg[i-1];
                rnz_reg[i]   <= rnz_reg[i-1];
            end
            zero_out_reg  <= (step_data[SHW] == '0);
            carry_out_reg <= carry_last;
        end
    end

    assign out_zero  = zero_out_reg;
    assign out_carry = carry_out_reg;
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter at WIDTH=8; flag checks build when SHIFTER_FLAGS_EN is defined.
module tb_pipelined_barrel_shifter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic [7:0] in_offset = '0;
    logic [2:0] in_mode = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
`ifdef SHIFTER_FLAGS_EN
    logic       out_zero;
    logic       out_carry;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    pipelined_barrel_shifter #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_offset (in_offset),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef SHIFTER_FLAGS_EN
        ,
        .out_zero  (out_zero),
        .out_carry (out_carry)
`endif
    );

    always #5 clk = ~clk;

    // Sends one operation into an empty pipe and waits (bounded) for its result.
    // lat counts cycles from the cycle the op was presented to the one showing its result.
    task automatic do_op(input logic [7:0] d, input logic [7:0] off, input logic [2:0] m,
                         output logic [7:0] res, output int lat,
                         output logic z, output logic c);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        in_offset = off;
        in_mode   = m;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = out_data;
`ifdef SHIFTER_FLAGS_EN
        z = out_zero;
        c = out_carry;
`else
        z = 1'b0;
        c = 1'b0;
`endif
        $display("[TB] op d=%02h off=%0d mode=%0d -> %02h lat=%0d z=%0b c=%0b", d, off, m, res, lat, z, c);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_out_valid: got %0b want 0", out_valid);
        end
        tests_run++;
        if (out_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_out_data: got %02h want 00", out_data);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %0b want 1", in_ready);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_lsl_latency();
        logic [7:0] r; int lat; logic z, c;
        do_op(8'h96, 8'd3, 3'b000, r, lat, z, c);
        tests_run++;
        if (r !== 8'hB0) begin tests_failed++; $display("FAIL lsl3_data: got %02h want b0", r); end
        tests_run++;
        if (lat !== 4) begin tests_failed++; $display("FAIL lsl3_latency: got %0d want 4", lat); end
`ifdef SHIFTER_FLAGS_EN
        tests_run++;
        if (c !== 1'b0 || z !== 1'b0) begin tests_failed++; $display("FAIL lsl3_flags: got z%0b c%0b want z0 c0", z, c); end
`endif
    endtask

    task automatic test_right_shifts();
        logic [7:0] r; int lat; logic z, c;
        do_op(8'h96, 8'd2, 3'b010, r, lat, z, c);
        tests_run++;
        if (r !== 8'hE5) begin tests_failed++; $display("FAIL asr2_data: got %02h want e5", r); end
`ifdef SHIFTER_FLAGS_EN
        tests_run++;
        if (c !== 1'b1) begin tests_failed++; $display("FAIL asr2_carry: got %0b want 1", c); end
`endif
        do_op(8'h96, 8'd9, 3'b010, r, lat, z, c);
        tests_run++;
        if (r !== 8'hFF) begin tests_failed++; $display("FAIL asr9_data: got %02h want ff", r); end
`ifdef SHIFTER_FLAGS_EN
        tests_run++;
        if (c !== 1'b1) begin tests_failed++; $display("FAIL asr9_carry: got %0b want 1", c); end
`endif
        do_op(8'h96, 8'd2, 3'b001, r, lat, z, c);
        tests_run++;
        if (r !== 8'h25) begin tests_failed++; $display("FAIL lsr2_data: got %02h want 25", r); end
        do_op(8'h96, 8'd8, 3'b010, r, lat, z, c);
        tests_run++;
        if (r !== 8'hFF) begin tests_failed++; $display("FAIL asr8_data: got %02h want ff", r); end
    endtask

    task automatic test_rotates();
        logic [7:0] r; int lat; logic z, c;
        do_op(8'h96, 8'd11, 3'b011, r, lat, z, c);
        tests_run++;
        if (r !== 8'hD2) begin tests_failed++; $display("FAIL ror11_data: got %02h want d2", r); end
`ifdef SHIFTER_FLAGS_EN
        tests_run++;
        if (c !== 1'b1) begin tests_failed++; $display("FAIL ror11_carry: got %0b want 1", c); end
`endif
        do_op(8'h96, 8'd1, 3'b100, r, lat, z, c);
        tests_run++;
        if (r !== 8'h2D) begin tests_failed++; $display("FAIL rol1_data: got %02h want 2d", r); end
`ifdef SHIFTER_FLAGS_EN
        tests_run++;
        if (c !== 1'b1) begin tests_failed++; $display("FAIL rol1_carry: got %0b want 1", c); end
`endif
        do_op(8'h96, 8'd8, 3'b011, r, lat, z, c);
        tests_run++;
        if (r !== 8'h96) begin tests_failed++; $display("FAIL ror8_data: got %02h want 96", r); end
        do_op(8'h81, 8'd6, 3'b100, r, lat, z, c);
        tests_run++;
        if (r !== 8'h60) begin tests_failed++; $display("FAIL rol6_data: got %02h want 60", r); end
    endtask

    task automatic test_boundaries();
        logic [7:0] r; int lat; logic z, c;
        do_op(8'hFF, 8'd8, 3'b001, r, lat, z, c);
        tests_run++;
        if (r !== 8'h00) begin tests_failed++; $display("FAIL lsr8_data: got %02h want 00", r); end
`ifdef SHIFTER_FLAGS_EN
        tests_run++;
        if (z !== 1'b1 || c !== 1'b1) begin tests_failed++; $display("FAIL lsr8_flags: got z%0b c%0b want z1 c1", z, c); end
`endif
        do_op(8'hFF, 8'd200, 3'b001, r, lat, z, c);
        tests_run++;
        if (r !== 8'h00) begin tests_failed++; $display("FAIL lsr200_data: got %02h want 00", r); end
`ifdef SHIFTER_FLAGS_EN
        tests_run++;
        if (c !== 1'b0) begin tests_failed++; $display("FAIL lsr200_carry: got %0b want 0", c); end
`endif
        do_op(8'h5A, 8'd3, 3'b111, r, lat, z, c);
        tests_run++;
        if (r !== 8'h5A) begin tests_failed++; $display("FAIL pass7_data: got %02h want 5a", r); end
        do_op(8'hC3, 8'd5, 3'b101, r, lat, z, c);
        tests_run++;
        if (r !== 8'hC3) begin tests_failed++; $display("FAIL pass5_data: got %02h want c3", r); end
        do_op(8'h96, 8'd0, 3'b000, r, lat, z, c);
        tests_run++;
        if (r !== 8'h96) begin tests_failed++; $display("FAIL lsl0_data: got %02h want 96", r); end
        do_op(8'h96, 8'd255, 3'b000, r, lat, z, c);
        tests_run++;
        if (r !== 8'h00) begin tests_failed++; $display("FAIL lsl255_data: got %02h want 00", r); end
`ifdef SHIFTER_FLAGS_EN
        do_op(8'h01, 8'd8, 3'b000, r, lat, z, c);
        tests_run++;
        if (c !== 1'b1) begin tests_failed++; $display("FAIL lsl8_carry: got %0b want 1", c); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [7:0] vd   [6] = '{8'h01, 8'h80, 8'h80, 8'h01, 8'h81, 8'h03};
        logic [7:0] voff [6] = '{8'd1,  8'd3,  8'd3,  8'd1,  8'd2,  8'd4};
        logic [2:0] vm   [6] = '{3'd0,  3'd1,  3'd2,  3'd3,  3'd4,  3'd0};
        logic [7:0] vexp [6] = '{8'h02, 8'h10, 8'hF0, 8'h80, 8'h06, 8'h30};
        int sent = 0;
        int recv = 0;
        int stalls = 0;
        logic want_ready;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc <= 6);
            in_valid  = (sent < 6);
            if (sent < 6) begin
                in_data   = vd[sent];
                in_offset = voff[sent];
                in_mode   = vm[sent];
            end
            #1;
            want_ready = !(cyc >= 4 && cyc <= 6);
            tests_run++;
            if (in_ready !== want_ready) begin
                tests_failed++;
                $display("FAIL b2b_in_ready cyc %0d: got %0b want %0b", cyc, in_ready, want_ready);
            end
            if (!in_ready) stalls++;
            if (out_valid && out_ready) begin
                tests_run++;
                if (recv >= 6) begin
                    tests_failed++;
                    $display("FAIL b2b_extra_result cyc %0d: got %02h want none", cyc, out_data);
                end else if (out_data !== vexp[recv]) begin
                    tests_failed++;
                    $display("FAIL b2b_result %0d: got %02h want %02h", recv, out_data, vexp[recv]);
                end
                $display("[TB] b2b cyc %0d result %0d = %02h", cyc, recv, out_data);
                recv++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tests_run++;
        if (recv !== 6) begin tests_failed++; $display("FAIL b2b_count: got %0d want 6", recv); end
        tests_run++;
        if (stalls !== 3) begin tests_failed++; $display("FAIL b2b_stall_cycles: got %0d want 3", stalls); end
    endtask

    task automatic test_reset_inflight();
        int seen = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_data   = 8'h10 + 8'(i);
            in_offset = 8'd1;
            in_mode   = 3'b000;
        end
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL rst_pre_valid: got %0b want 1", out_valid); end
        rst = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_async_valid: got %0b want 0", out_valid); end
        tests_run++;
        if (out_data !== 8'h00) begin tests_failed++; $display("FAIL rst_async_data: got %02h want 00", out_data); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_release_ready: got %0b want 1", in_ready); end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        tests_run++;
        if (seen !== 0) begin tests_failed++; $display("FAIL rst_no_results: got %0d want 0", seen); end
        $display("[TB] reset with ops in flight checked");
    endtask

    initial begin
        test_reset();
        test_lsl_latency();
        test_right_shifts();
        test_rotates();
        test_boundaries();
        test_back_to_back();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
